// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and round-constant lookup
// for the sequential AES-128 key schedule.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;
    localparam int NRK   = NR + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: 8-bit combinational byte substitution,
// used four times in parallel for SubWord.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    always_comb begin
        out_o = 8'h00;
        case (in_i)
            8'h00: out_o = 8'h63; 8'h01: out_o = 8'h7c;
            8'h02: out_o = 8'h77; 8'h03: out_o = 8'h7b;
            8'h04: out_o = 8'hf2; 8'h05: out_o = 8'h6b;
            8'h06: out_o = 8'h6f; 8'h07: out_o = 8'hc5;
            8'h08: out_o = 8'h30; 8'h09: out_o = 8'h01;
            8'h0a: out_o = 8'h67; 8'h0b: out_o = 8'h2b;
            8'h0c: out_o = 8'hfe; 8'h0d: out_o = 8'hd7;
            8'h0e: out_o = 8'hab; 8'h0f: out_o = 8'h76;
            8'h10: out_o = 8'hca; 8'h11: out_o = 8'h82;
            8'h12: out_o = 8'hc9; 8'h13: out_o = 8'h7d;
            8'h14: out_o = 8'hfa; 8'h15: out_o = 8'h59;
            8'h16: out_o = 8'h47; 8'h17: out_o = 8'hf0;
            8'h18: out_o = 8'had; 8'h19: out_o = 8'hd4;
            8'h1a: out_o = 8'ha2; 8'h1b: out_o = 8'haf;
            8'h1c: out_o = 8'h9c; 8'h1d: out_o = 8'ha4;
            8'h1e: out_o = 8'h72; 8'h1f: out_o = 8'hc0;
            8'h20: out_o = 8'hb7; 8'h21: out_o = 8'hfd;
            8'h22: out_o = 8'h93; 8'h23: out_o = 8'h26;
            8'h24: out_o = 8'h36; 8'h25: out_o = 8'h3f;
            8'h26: out_o = 8'hf7; 8'h27: out_o = 8'hcc;
            8'h28: out_o = 8'h34; 8'h29: out_o = 8'ha5;
            8'h2a: out_o = 8'he5; 8'h2b: out_o = 8'hf1;
            8'h2c: out_o = 8'h71; 8'h2d: out_o = 8'hd8;
            8'h2e: out_o = 8'h31; 8'h2f: out_o = 8'h15;
            8'h30: out_o = 8'h04; 8'h31: out_o = 8'hc7;
            8'h32: out_o = 8'h23; 8'h33: out_o = 8'hc3;
            8'h34: out_o = 8'h18; 8'h35: out_o = 8'h96;
            8'h36: out_o = 8'h05; 8'h37: out_o = 8'h9a;
            8'h38: out_o = 8'h07; 8'h39: out_o = 8'h12;
            8'h3a: out_o = 8'h80; 8'h3b: out_o = 8'he2;
            8'h3c: out_o = 8'heb; 8'h3d: out_o = 8'h27;
            8'h3e: out_o = 8'hb2; 8'h3f: out_o = 8'h75;
            8'h40: out_o = 8'h09; 8'h41: out_o = 8'h83;
            8'h42: out_o = 8'h2c; 8'h43: out_o = 8'h1a;
            8'h44: out_o = 8'h1b; 8'h45: out_o = 8'h6e;
            8'h46: out_o = 8'h5a; 8'h47: out_o = 8'ha0;
            8'h48: out_o = 8'h52; 8'h49: out_o = 8'h3b;
            8'h4a: out_o = 8'hd6; 8'h4b: out_o = 8'hb3;
            8'h4c: out_o = 8'h29; 8'h4d: out_o = 8'he3;
            8'h4e: out_o = 8'h2f; 8'h4f: out_o = 8'h84;
            8'h50: out_o = 8'h53; 8'h51: out_o = 8'hd1;
            8'h52: out_o = 8'h00; 8'h53: out_o = 8'hed;
            8'h54: out_o = 8'h20; 8'h55: out_o = 8'hfc;
            8'h56: out_o = 8'hb1; 8'h57: out_o = 8'h5b;
            8'h58: out_o = 8'h6a; 8'h59: out_o = 8'hcb;
            8'h5a: out_o = 8'hbe; 8'h5b: out_o = 8'h39;
            8'h5c: out_o = 8'h4a; 8'h5d: out_o = 8'h4c;
            8'h5e: out_o = 8'h58; 8'h5f: out_o = 8'hcf;
            8'h60: out_o = 8'hd0; 8'h61: out_o = 8'hef;
            8'h62: out_o = 8'haa; 8'h63: out_o = 8'hfb;
            8'h64: out_o = 8'h43; 8'h65: out_o = 8'h4d;
            8'h66: out_o = 8'h33; 8'h67: out_o = 8'h85;
            8'h68: out_o = 8'h45; 8'h69: out_o = 8'hf9;
            8'h6a: out_o = 8'h02; 8'h6b: out_o = 8'h7f;
            8'h6c: out_o = 8'h50; 8'h6d: out_o = 8'h3c;
            8'h6e: out_o = 8'h9f; 8'h6f: out_o = 8'ha8;
            8'h70: out_o = 8'h51; 8'h71: out_o = 8'ha3;
            8'h72: out_o = 8'h40; 8'h73: out_o = 8'h8f;
            8'h74: out_o = 8'h92; 8'h75: out_o = 8'h9d;
            8'h76: out_o = 8'h38; 8'h77: out_o = 8'hf5;
            8'h78: out_o = 8'hbc; 8'h79: out_o = 8'hb6;
            8'h7a: out_o = 8'hda; 8'h7b: out_o = 8'h21;
            8'h7c: out_o = 8'h10; 8'h7d: out_o = 8'hff;
            8'h7e: out_o = 8'hf3; 8'h7f: out_o = 8'hd2;
            8'h80: out_o = 8'hcd; 8'h81: out_o = 8'h0c;
            8'h82: out_o = 8'h13; 8'h83: out_o = 8'hec;
            8'h84: out_o = 8'h5f; 8'h85: out_o = 8'h97;
            8'h86: out_o = 8'h44; 8'h87: out_o = 8'h17;
            8'h88: out_o = 8'hc4; 8'h89: out_o = 8'ha7;
            8'h8a: out_o = 8'h7e; 8'h8b: out_o = 8'h3d;
            8'h8c: out_o = 8'h64; 8'h8d: out_o = 8'h5d;
            8'h8e: out_o = 8'h19; 8'h8f: out_o = 8'h73;
            8'h90: out_o = 8'h60; 8'h91: out_o = 8'h81;
            8'h92: out_o = 8'h4f; 8'h93: out_o = 8'hdc;
            8'h94: out_o = 8'h22; 8'h95: out_o = 8'h2a;
            8'h96: out_o = 8'h90; 8'h97: out_o = 8'h88;
            8'h98: out_o = 8'h46; 8'h99: out_o = 8'hee;
            8'h9a: out_o = 8'hb8; 8'h9b: out_o = 8'h14;
            8'h9c: out_o = 8'hde; 8'h9d: out_o = 8'h5e;
            8'h9e: out_o = 8'h0b; 8'h9f: out_o = 8'hdb;
            8'ha0: out_o = 8'he0; 8'ha1: out_o = 8'h32;
            8'ha2: out_o = 8'h3a; 8'ha3: out_o = 8'h0a;
            8'ha4: out_o = 8'h49; 8'ha5: out_o = 8'h06;
            8'ha6: out_o = 8'h24; 8'ha7: out_o = 8'h5c;
            8'ha8: out_o = 8'hc2; 8'ha9: out_o = 8'hd3;
            8'haa: out_o = 8'hac; 8'hab: out_o = 8'h62;
            8'hac: out_o = 8'h91; 8'had: out_o = 8'h95;
            8'hae: out_o = 8'he4; 8'haf: out_o = 8'h79;
            8'hb0: out_o = 8'he7; 8'hb1: out_o = 8'hc8;
            8'hb2: out_o = 8'h37; 8'hb3: out_o = 8'h6d;
            8'hb4: out_o = 8'h8d; 8'hb5: out_o = 8'hd5;
            8'hb6: out_o = 8'h4e; 8'hb7: out_o = 8'ha9;
            8'hb8: out_o = 8'h6c; 8'hb9: out_o = 8'h56;
            8'hba: out_o = 8'hf4; 8'hbb: out_o = 8'hea;
            8'hbc: out_o = 8'h65; 8'hbd: out_o = 8'h7a;
            8'hbe: out_o = 8'hae; 8'hbf: out_o = 8'h08;
            8'hc0: out_o = 8'hba; 8'hc1: out_o = 8'h78;
            8'hc2: out_o = 8'h25; 8'hc3: out_o = 8'h2e;
            8'hc4: out_o = 8'h1c; 8'hc5: out_o = 8'ha6;
            8'hc6: out_o = 8'hb4; 8'hc7: out_o = 8'hc6;
            8'hc8: out_o = 8'he8; 8'hc9: out_o = 8'hdd;
            8'hca: out_o = 8'h74; 8'hcb: out_o = 8'h1f;
            8'hcc: out_o = 8'h4b; 8'hcd: out_o = 8'hbd;
            8'hce: out_o = 8'h8b; 8'hcf: out_o = 8'h8a;
            8'hd0: out_o = 8'h70; 8'hd1: out_o = 8'h3e;
            8'hd2: out_o = 8'hb5; 8'hd3: out_o = 8'h66;
            8'hd4: out_o = 8'h48; 8'hd5: out_o = 8'h03;
            8'hd6: out_o = 8'hf6; 8'hd7: out_o = 8'h0e;
            8'hd8: out_o = 8'h61; 8'hd9: out_o = 8'h35;
            8'hda: out_o = 8'h57; 8'hdb: out_o = 8'hb9;
            8'hdc: out_o = 8'h86; 8'hdd: out_o = 8'hc1;
            8'hde: out_o = 8'h1d; 8'hdf: out_o = 8'h9e;
            8'he0: out_o = 8'he1; 8'he1: out_o = 8'hf8;
            8'he2: out_o = 8'h98; 8'he3: out_o = 8'h11;
            8'he4: out_o = 8'h69; 8'he5: out_o = 8'hd9;
            8'he6: out_o = 8'h8e; 8'he7: out_o = 8'h94;
            8'he8: out_o = 8'h9b; 8'he9: out_o = 8'h1e;
            8'hea: out_o = 8'h87; 8'heb: out_o = 8'he9;
            8'hec: out_o = 8'hce; 8'hed: out_o = 8'h55;
            8'hee: out_o = 8'h28; 8'hef: out_o = 8'hdf;
            8'hf0: out_o = 8'h8c; 8'hf1: out_o = 8'ha1;
            8'hf2: out_o = 8'h89; 8'hf3: out_o = 8'h0d;
            8'hf4: out_o = 8'hbf; 8'hf5: out_o = 8'he6;
            8'hf6: out_o = 8'h42; 8'hf7: out_o = 8'h68;
            8'hf8: out_o = 8'h41; 8'hf9: out_o = 8'h99;
            8'hfa: out_o = 8'h2d; 8'hfb: out_o = 8'h0f;
            8'hfc: out_o = 8'hb0; 8'hfd: out_o = 8'h54;
            8'hfe: out_o = 8'hbb; 8'hff: out_o = 8'h16;
            default: out_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes128_key_schedule_seq.sv
// Sequential AES-128 key expansion: one round key per clock into an
// 11-entry store, served through a registered indexed read port.
module aes128_key_schedule_seq
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_valid
);

    state_e           state_q;
    logic [3:0]       round_q;
    logic [KEY_W-1:0] rk_q [NRK];
    logic [KEY_W-1:0] rk_out_q;
    logic             rk_valid_q;
    logic             done_q;

    logic [KEY_W-1:0] cur_rk;
    logic [KEY_W-1:0] rk_d;
    logic [31:0]      rot_w;
    logic [31:0]      sub_w;
    logic [31:0]      t_w;
    logic [31:0]      n0, n1, n2, n3;
    logic             idx_ok;

    // Single shared f() datapath, steered by the round counter.
    assign cur_rk = rk_q[round_q];
    assign rot_w  = {cur_rk[23:0], cur_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .in_i  (rot_w[8*g +: 8]),
            .out_o (sub_w[8*g +: 8])
        );
    end

    assign t_w  = sub_w ^ {rcon(round_q), 24'h0};
    assign n0   = cur_rk[127:96] ^ t_w;
    assign n1   = cur_rk[95:64]  ^ n0;
    assign n2   = cur_rk[63:32]  ^ n1;
    assign n3   = cur_rk[31:0]   ^ n2;
    assign rk_d = {n0, n1, n2, n3};

    assign idx_ok    = (rk_idx <= 4'(NR));
    assign key_ready = (state_q != ST_EXPAND);
    assign busy      = (state_q == ST_EXPAND);
    assign done      = done_q;
    assign rk_out    = rk_out_q;
    assign rk_valid  = rk_valid_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q    <= ST_IDLE;
            round_q    <= 4'd0;
            rk_out_q   <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NRK; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            rk_out_q   <= idx_ok ? rk_q[rk_idx] : '0;
            rk_valid_q <= idx_ok && (state_q == ST_READY);
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (key_valid) begin
                        rk_q[0] <= key_in;
                        round_q <= 4'd0;
                        state_q <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    rk_q[round_q + 4'd1] <= rk_d;
                    round_q <= round_q + 4'd1;
                    if (round_q == 4'(NR - 1)) begin
                        round_q <= 4'd0;
                        state_q <= ST_READY;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_key_schedule_seq.sv
// Scoreboard bench for the sequential AES-128 key schedule; the
// reference model derives its S-box from GF(2^8) inversion.
module tb_aes128_key_schedule_seq;

    logic         clk;
    logic         rst;
    logic         clear;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;

    aes128_key_schedule_seq dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ZERO = 128'h0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sb_m [256];
    logic [127:0] mrk  [11];

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] rk;
        logic         v;
    } rd_t;

    rd_t sbq [$];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_m[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
                      ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc   = 8'h01;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]],
                     sb_m[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // Monitor: each read issued at a negedge is compared just after the next posedge.
    always @(posedge clk) begin
        rd_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("rk_out[%0d]", e.idx), rk_out, e.rk);
            chk($sformatf("rk_valid[%0d]", e.idx), {127'b0, rk_valid},
                {127'b0, e.v});
        end
    end

    task automatic rd(input logic [3:0] i, input logic [127:0] e,
                      input logic v);
        rk_idx = i;
        sbq.push_back('{idx: i, rk: e, v: v});
        @(negedge clk);
    endtask

    task automatic rd_all();
        for (int i = 0; i < 11; i++) rd(4'(i), mrk[i], 1'b1);
    endtask

    task automatic load_key(input logic [127:0] k, input bit hold,
                            input logic [127:0] alt);
        int lat;
        lat       = 0;
        key_in    = k;
        key_valid = 1'b1;
        chk("key_ready_pre", {127'b0, key_ready}, 128'd1);
        @(negedge clk);
        chk("busy_exp", {127'b0, busy}, 128'd1);
        chk("key_ready_exp", {127'b0, key_ready}, 128'd0);
        if (hold) key_in = alt;
        else key_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) chk("rk_valid_exp", {127'b0, rk_valid}, 128'd0);
            if (c < 10) chk("key_ready_hold", {127'b0, key_ready}, 128'd0);
            if (hold && c == 9) key_valid = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk("done_latency", 128'(lat), 128'd10);
        @(negedge clk);
        chk("done_once", {127'b0, done}, 128'd0);
        chk("busy_ready", {127'b0, busy}, 128'd0);
        chk("key_ready_post", {127'b0, key_ready}, 128'd1);
        expand(k);
    endtask

    task automatic abort_test(input bit use_clear);
        string nm;
        nm        = use_clear ? "clr" : "rst";
        rk_idx    = 4'd0;
        key_in    = K_FIPS;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        if (use_clear) clear = 1'b1;
        else rst = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        rst   = 1'b0;
        chk({nm, "_key_ready"}, {127'b0, key_ready}, 128'd1);
        chk({nm, "_busy"}, {127'b0, busy}, 128'd0);
        chk({nm, "_done"}, {127'b0, done}, 128'd0);
        chk({nm, "_rk_out"}, rk_out, 128'd0);
        chk({nm, "_rk_valid"}, {127'b0, rk_valid}, 128'd0);
        for (int i = 0; i < 11; i++) begin
            rd(4'(i), 128'd0, 1'b0);
            chk({nm, "_no_done"}, {127'b0, done}, 128'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_idx    = 4'd0;
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_key_ready", {127'b0, key_ready}, 128'd1);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_done", {127'b0, done}, 128'd0);
        chk("rst_rk_out", rk_out, 128'd0);
        chk("rst_rk_valid", {127'b0, rk_valid}, 128'd0);

        load_key(K_FIPS, 1'b0, K_ZERO);
        rd_all();
        rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        rd(4'd11, 128'd0, 1'b0);
        rd(4'd15, 128'd0, 1'b0);
        rd(4'd10, mrk[10], 1'b1);

        load_key(K_ZERO, 1'b0, K_ZERO);
        rd_all();
        rd(4'd0, 128'd0, 1'b1);
        rd(4'd1, 128'h62636363626363636263636362636363, 1'b1);
        rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1);

        load_key(K_FIPS, 1'b1, K_ZERO);
        rd_all();
        rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);

        abort_test(1'b0);
        load_key(K_FIPS, 1'b0, K_ZERO);
        rd(4'd5, mrk[5], 1'b1);
        abort_test(1'b1);

        for (int n = 0; n < 3; n++) begin
            load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, K_ZERO);
            rd_all();
            rd(4'd12, 128'd0, 1'b0);
        end

        @(negedge clk);
        chk("sb_drained", 128'(sbq.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
